// File: rtl/sqrt_lab_pkg.sv
// sqrt_lab_pkg: shared types and constants for the square-root lab front-end, datapath and display.
package sqrt_lab_pkg;
    localparam int OPERAND_WIDTH = 4;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int REPEAT_CYCLES_DEFAULT = 50000000;
    typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, HELD, CONFIRM_RELEASE} deb_state_e;
    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/start_request_conditioner_if.sv
// start_request_conditioner_if: button/switch request bundle between the lab front panel and the sqrt engine.
interface start_request_conditioner_if
    import sqrt_lab_pkg::*;
#(
    parameter int WIDTH = OPERAND_WIDTH
);
    logic             button;
    logic [WIDTH-1:0] switches;
    logic             ready;
    logic             start;
    logic [WIDTH-1:0] operand;
    logic             pending;
    modport master(output button, switches, ready, input start, operand, pending);
    modport slave(input button, switches, ready, output start, operand, pending);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: parameterised-width two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/start_request_conditioner.sv
// start_request_conditioner: debounced one-shot start pulse with operand capture for the sqrt lab.
// Defining START_REQUEST_REPEAT_EN adds auto-repeat requests while the button stays held.
module start_request_conditioner
    import sqrt_lab_pkg::*;
#(
    parameter int WIDTH           = OPERAND_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
    input logic clock,
    input logic reset,
    start_request_conditioner_if.slave bus
);
    localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES));
    logic             btn_s;
    logic [WIDTH-1:0] sw_s;
    deb_state_e       state;
    logic [CW-1:0]    cnt;
    logic             pending_r, start_r;
    logic [WIDTH-1:0] pend_op, operand_r;
    logic             stable_done, repeat_done, req, launch;
    sync_2ff #(.W(1)) u_btn_sync (.clock(clock), .reset(reset), .d(bus.button), .q(btn_s));
    sync_2ff #(.W(WIDTH)) u_sw_sync (.clock(clock), .reset(reset), .d(bus.switches), .q(sw_s));
    assign stable_done = cnt == CW'(DEBOUNCE_CYCLES - 1);
`ifdef START_REQUEST_REPEAT_EN
    assign repeat_done = state == HELD && btn_s && cnt == CW'(REPEAT_CYCLES - 1);
`else
    assign repeat_done = 1'b0;
`endif
    assign req    = (state == CONFIRM_PRESS && btn_s && stable_done) || repeat_done;
    assign launch = pending_r && bus.ready;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pending_r <= 1'b0;
            pend_op   <= '0;
            start_r   <= 1'b0;
            operand_r <= '0;
        end else begin
            case (state)
                IDLE: if (btn_s) begin
                    state <= CONFIRM_PRESS;
                    cnt   <= '0;
                end
                CONFIRM_PRESS: if (!btn_s) state <= IDLE;
                else if (stable_done) begin
                    state <= HELD;
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
                HELD: if (!btn_s) begin
                    state <= CONFIRM_RELEASE;
                    cnt   <= '0;
                end
`ifdef START_REQUEST_REPEAT_EN
                else cnt <= repeat_done ? '0 : cnt + 1'b1;
`endif
                CONFIRM_RELEASE: if (btn_s) begin
                    state <= HELD;
                    cnt   <= '0;
                end else if (stable_done) state <= IDLE;
                else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
            // launch consumes the old pend_op; a same-edge request refills the slot
            start_r   <= launch;
            pending_r <= req || (pending_r && !launch);
            if (launch) operand_r <= pend_op;
            if (req && (!pending_r || launch)) pend_op <= sw_s;
        end
    end
    assign bus.start   = start_r;
    assign bus.operand = operand_r;
    assign bus.pending = pending_r;
endmodule
